// File: rtl/rs_tx_pkg.sv
// rtl/rs_tx_pkg.sv - shared symbol, tag, code and state definitions for the RS transmit packer
package rs_tx_pkg;

   localparam logic [4:0] SYM_ZERO     = 5'b00001;
   localparam logic [4:0] SYM_ONE      = 5'b00010;
   localparam logic [4:0] SYM_EXT_ERR  = 5'b00100;
   localparam logic [4:0] SYM_EXT      = 5'b01000;
   localparam logic [4:0] SYM_END      = 5'b10000;

   typedef enum logic [1:0] {
      TAG_DATA    = 2'd0,
      TAG_EXT     = 2'd1,
      TAG_EXT_ERR = 2'd2,
      TAG_END     = 2'd3
   } tag_e;

   localparam logic [7:0] EXT_CODE     = 8'h0F;
   localparam logic [7:0] EXT_ERR_CODE = 8'h1F;

   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   localparam logic [3:0] PRE_NIB  = 4'h5;
   localparam logic [3:0] SFD_NIB  = 4'hD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_FRAME = 2'd2
   } tx_state_e;

endpackage

// File: rtl/rs_tx_fifo.sv
// rtl/rs_tx_fifo.sv - synchronous FIFO with push/pop/count; caller never pushes when full or pops when empty
module rs_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/rs_tx_packer.sv
// rtl/rs_tx_packer.sv - packs PLS symbols into words and drives txd/tx_en/tx_er once per gtx_clk
// Optional preamble/SFD insertion on frame start: define RS_TX_PREAMBLE_EN.
module rs_tx_packer
   import rs_tx_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        pls_data_request,
   input  logic              pls_valid,
   output logic              pls_ready,
   input  logic              err_clr,
   output logic              gtx_clk,
   output logic [DATA_W-1:0] txd,
   output logic              tx_en,
   output logic              tx_er,
   output logic [2:0]        err_status
);

   localparam int CW   = $clog2(CLK_DIV);
   localparam int BW   = $clog2(DATA_W);
   localparam int FW   = DATA_W + 2;
   localparam int CNTW = $clog2(DEPTH) + 1;

   localparam logic [DATA_W-1:0] EXT_SYM     = EXT_CODE[DATA_W-1:0];
   localparam logic [DATA_W-1:0] EXT_ERR_SYM = EXT_ERR_CODE[DATA_W-1:0];

`ifdef RS_TX_PREAMBLE_EN
   localparam logic [4:0]        PRE_N   = (DATA_W == 8) ? 5'd7 : 5'd15;
   localparam logic [DATA_W-1:0] PRE_SYM = (DATA_W == 8) ? DATA_W'(PRE_BYTE) : DATA_W'(PRE_NIB);
   localparam logic [DATA_W-1:0] SFD_SYM = (DATA_W == 8) ? DATA_W'(SFD_BYTE) : DATA_W'(SFD_NIB);

   logic [4:0]        pre_cnt_q, pre_cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
`endif

   logic [CW-1:0]     cnt_q, cnt_d;
   logic              tick;
   logic              gtx_clk_q, gtx_clk_d;
   logic              live_q;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [2:0]        err_q, err_d;
   logic [1:0]        sym_err;
   logic              underrun;

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] txd_q, txd_d;
   logic              en_q, en_d;
   logic              er_q, er_d;

   logic              accept;
   logic              push, pop;
   tag_e              push_tag, rd_tag;
   logic [DATA_W-1:0] push_word, rd_data;
   logic [FW-1:0]     rdata;
   logic [CNTW-1:0]   fifo_count;
   logic              fifo_empty;

   // live_q keeps pls_ready low until the first clock after reset release
   assign pls_ready  = live_q && (fifo_count < CNTW'(DEPTH));
   assign accept     = pls_valid && pls_ready;
   assign fifo_empty = (fifo_count == '0);
   assign tick       = (cnt_q == CW'(CLK_DIV - 1));
   assign rd_tag     = tag_e'(rdata[FW-1:DATA_W]);
   assign rd_data    = rdata[DATA_W-1:0];

   always_comb begin
      cnt_d     = tick ? '0 : cnt_q + CW'(1);
      gtx_clk_d = (cnt_d < CW'(CLK_DIV / 2));
   end

   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      push      = 1'b0;
      push_tag  = TAG_DATA;
      push_word = '0;
      sym_err   = 2'b00;
      if (accept) begin
         case (pls_data_request)
            SYM_ZERO, SYM_ONE: begin
               shreg_d[bit_cnt_q] = (pls_data_request == SYM_ONE);
               if (bit_cnt_q == BW'(DATA_W - 1)) begin
                  push      = 1'b1;
                  push_word = shreg_d;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
            SYM_EXT, SYM_EXT_ERR, SYM_END: begin
               push       = 1'b1;
               push_tag   = (pls_data_request == SYM_EXT)     ? TAG_EXT :
                            (pls_data_request == SYM_EXT_ERR) ? TAG_EXT_ERR : TAG_END;
               sym_err[1] = (bit_cnt_q != '0);
               bit_cnt_d  = '0;
            end
            default: sym_err[0] = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      txd_d    = txd_q;
      en_d     = en_q;
      er_d     = er_q;
      pop      = 1'b0;
      underrun = 1'b0;
`ifdef RS_TX_PREAMBLE_EN
      pre_cnt_d = pre_cnt_q;
      hold_d    = hold_q;
`endif
      if (tick) begin
`ifdef RS_TX_PREAMBLE_EN
         // the popped DATA word waits in hold_q until preamble and SFD are out
         if (state_q == ST_PRE) begin
            en_d = 1'b1;
            er_d = 1'b0;
            if (pre_cnt_q < PRE_N) begin
               txd_d     = PRE_SYM;
               pre_cnt_d = pre_cnt_q + 5'd1;
            end else if (pre_cnt_q == PRE_N) begin
               txd_d     = SFD_SYM;
               pre_cnt_d = pre_cnt_q + 5'd1;
            end else begin
               txd_d   = hold_q;
               state_d = ST_FRAME;
            end
         end else
`endif
         if (!fifo_empty) begin
            pop = 1'b1;
            case (rd_tag)
               TAG_DATA: begin
                  en_d = 1'b1;
                  er_d = 1'b0;
`ifdef RS_TX_PREAMBLE_EN
                  if (state_q == ST_IDLE) begin
                     txd_d     = PRE_SYM;
                     pre_cnt_d = 5'd1;
                     hold_d    = rd_data;
                     state_d   = ST_PRE;
                  end else begin
                     txd_d   = rd_data;
                     state_d = ST_FRAME;
                  end
`else
                  txd_d   = rd_data;
                  state_d = ST_FRAME;
`endif
               end
               TAG_EXT: begin
                  txd_d = EXT_SYM;
                  en_d  = 1'b0;
                  er_d  = 1'b1;
               end
               TAG_EXT_ERR: begin
                  txd_d = EXT_ERR_SYM;
                  en_d  = 1'b0;
                  er_d  = 1'b1;
               end
               TAG_END: begin
                  txd_d   = '0;
                  en_d    = 1'b0;
                  er_d    = 1'b0;
                  state_d = ST_IDLE;
               end
            endcase
         end else if (state_q == ST_FRAME) begin
            txd_d    = '0;
            en_d     = 1'b1;
            er_d     = 1'b1;
            underrun = 1'b1;
         end else begin
            txd_d = '0;
            en_d  = 1'b0;
            er_d  = 1'b0;
         end
      end
   end

   // a new error in the same cycle as err_clr survives the clear
   always_comb begin
      err_d = (err_clr ? 3'b000 : err_q) | {underrun, sym_err};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         gtx_clk_q <= 1'b0;
         live_q    <= 1'b0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         err_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         gtx_clk_q <= gtx_clk_d;
         live_q    <= 1'b1;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         txd_q     <= '0;
         en_q      <= 1'b0;
         er_q      <= 1'b0;
`ifdef RS_TX_PREAMBLE_EN
         pre_cnt_q <= '0;
         hold_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         txd_q     <= txd_d;
         en_q      <= en_d;
         er_q      <= er_d;
`ifdef RS_TX_PREAMBLE_EN
         pre_cnt_q <= pre_cnt_d;
         hold_q    <= hold_d;
`endif
      end
   end

   rs_tx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({push_tag, push_word}),
      .pop   (pop),
      .rdata (rdata),
      .count (fifo_count)
   );

   assign gtx_clk    = gtx_clk_q;
   assign txd        = txd_q;
   assign tx_en      = en_q;
   assign tx_er      = er_q;
   assign err_status = err_q;

endmodule

// File: tb/tb_rs_tx_packer.sv
// tb/tb_rs_tx_packer.sv - randomized and directed bench for rs_tx_packer against a queue-based model
module tb_rs_tx_packer;

   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 2;
   localparam int DEPTH   = 4;
`ifdef RS_TX_PREAMBLE_EN
   localparam bit PRE_EN  = 1'b1;
`else
   localparam bit PRE_EN  = 1'b0;
`endif
   localparam int PRE_N   = (DATA_W == 8) ? 7 : 15;

   localparam logic [DATA_W-1:0] EXT_D     = DATA_W'(8'h0F);
   localparam logic [DATA_W-1:0] EXT_ERR_D = DATA_W'(8'h1F);
   localparam logic [DATA_W-1:0] PRE_D     = (DATA_W == 8) ? DATA_W'(8'h55) : DATA_W'(4'h5);
   localparam logic [DATA_W-1:0] SFD_D     = (DATA_W == 8) ? DATA_W'(8'hD5) : DATA_W'(4'hD);

   // kinds: 0 ZERO, 1 ONE, 2 EXTEND_ERROR, 3 EXTEND, 4 DATA_COMPLETE, 5.. illegal patterns
   localparam int K_EXT_ERR = 2;
   localparam int K_EXT     = 3;
   localparam int K_END     = 4;
   localparam int K_ILL     = 5;

   typedef struct { logic [DATA_W-1:0] d; bit en; bit er; } out_t;
   typedef struct { int tag; logic [DATA_W-1:0] d; } ent_t;

   logic              clk;
   logic              reset;
   logic [4:0]        pls_data_request;
   logic              pls_valid;
   logic              pls_ready;
   logic              err_clr;
   logic              gtx_clk;
   logic [DATA_W-1:0] txd;
   logic              tx_en;
   logic              tx_er;
   logic [2:0]        err_status;

   logic [4:0] ill_tab [4] = '{5'b00000, 5'b00011, 5'b11111, 5'b10100};

   ent_t              fifo_m [$];
   out_t              pend_m [$];
   out_t              out_m;
   int                cnt_m;
   bit                rdy_m;
   bit                gtx_m;
   bit                frame_m;
   int                nbits_m;
   logic [DATA_W-1:0] word_m;
   logic [2:0]        err_m;

   bit v_i;
   int k_i;
   bit clr_i;

   int n_chk;
   int n_fail;

   rs_tx_packer #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV),
      .DEPTH   (DEPTH)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .pls_data_request (pls_data_request),
      .pls_valid        (pls_valid),
      .pls_ready        (pls_ready),
      .err_clr          (err_clr),
      .gtx_clk          (gtx_clk),
      .txd              (txd),
      .tx_en            (tx_en),
      .tx_er            (tx_er),
      .err_status       (err_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic out_t mk(input logic [DATA_W-1:0] d, input bit en, input bit er);
      out_t o;
      o.d  = d;
      o.en = en;
      o.er = er;
      return o;
   endfunction

   function automatic logic [4:0] sym(input int k);
      logic [4:0] one = 5'b00001;
      if (k < K_ILL) return one << k;
      return ill_tab[k - K_ILL];
   endfunction

   task automatic model_reset();
      fifo_m.delete();
      pend_m.delete();
      out_m   = mk('0, 1'b0, 1'b0);
      cnt_m   = 0;
      rdy_m   = 1'b0;
      gtx_m   = 1'b0;
      frame_m = 1'b0;
      nbits_m = 0;
      word_m  = '0;
      err_m   = 3'b000;
   endtask

   // one clock edge of the reference: drain at gtx rate, then absorb the accepted symbol
   task automatic model_edge();
      bit         tick = (cnt_m == CLK_DIV - 1);
      bit         acc  = v_i && rdy_m;
      logic [2:0] set  = 3'b000;
      ent_t       e;
      if (tick) begin
         if (pend_m.size() > 0) begin
            out_m = pend_m.pop_front();
         end else if (fifo_m.size() > 0) begin
            e = fifo_m.pop_front();
            case (e.tag)
               0: begin
                  if (!frame_m && PRE_EN) begin
                     out_m = mk(PRE_D, 1'b1, 1'b0);
                     for (int i = 1; i < PRE_N; i++) pend_m.push_back(mk(PRE_D, 1'b1, 1'b0));
                     pend_m.push_back(mk(SFD_D, 1'b1, 1'b0));
                     pend_m.push_back(mk(e.d, 1'b1, 1'b0));
                  end else begin
                     out_m = mk(e.d, 1'b1, 1'b0);
                  end
                  frame_m = 1'b1;
               end
               1: out_m = mk(EXT_D, 1'b0, 1'b1);
               2: out_m = mk(EXT_ERR_D, 1'b0, 1'b1);
               default: begin
                  out_m   = mk('0, 1'b0, 1'b0);
                  frame_m = 1'b0;
               end
            endcase
         end else if (frame_m) begin
            out_m  = mk('0, 1'b1, 1'b1);
            set[2] = 1'b1;
         end else begin
            out_m = mk('0, 1'b0, 1'b0);
         end
      end
      if (acc) begin
         if (k_i <= 1) begin
            word_m[nbits_m] = k_i[0];
            nbits_m++;
            if (nbits_m == DATA_W) begin
               fifo_m.push_back('{0, word_m});
               nbits_m = 0;
            end
         end else if (k_i < K_ILL) begin
            if (nbits_m != 0) set[1] = 1'b1;
            nbits_m = 0;
            fifo_m.push_back('{(k_i == K_EXT) ? 1 : (k_i == K_EXT_ERR) ? 2 : 3, '0});
         end else begin
            set[0] = 1'b1;
         end
      end
      err_m = (clr_i ? 3'b000 : err_m) | set;
      cnt_m = (cnt_m + 1) % CLK_DIV;
      gtx_m = (cnt_m < CLK_DIV / 2);
      rdy_m = (fifo_m.size() < DEPTH);
   endtask

   task automatic check_outputs();
      chk("txd", 32'(txd), 32'(out_m.d));
      chk("tx_en", 32'(tx_en), 32'(out_m.en));
      chk("tx_er", 32'(tx_er), 32'(out_m.er));
      chk("gtx_clk", 32'(gtx_clk), 32'(gtx_m));
      chk("pls_ready", 32'(pls_ready), 32'(rdy_m));
      chk("err_status", 32'(err_status), 32'(err_m));
   endtask

   task automatic step(input bit v, input int k, input bit clr);
      v_i              = v;
      k_i              = k;
      clr_i            = clr;
      pls_valid        = v;
      pls_data_request = v ? sym(k) : 5'b00000;
      err_clr          = clr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send(input int k);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         done = rdy_m;
         step(1'b1, k, 1'b0);
      end
      chk("send_accept", 32'(done), 32'd1);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w);
      for (int i = 0; i < DATA_W; i++) send(int'(w[i]));
   endtask

   task automatic wait_out(input string tag, input logic [DATA_W-1:0] d, input bit en, input bit er,
                           input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         step(1'b0, 0, 1'b0);
         if (txd === d && tx_en === en && tx_er === er) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
   endtask

   function automatic int rand_kind();
      int r = int'($urandom_range(99));
      if (r < 40) return 0;
      if (r < 80) return 1;
      if (r < 86) return K_EXT;
      if (r < 90) return K_EXT_ERR;
      if (r < 97) return K_END;
      return K_ILL + int'($urandom_range(3));
   endfunction

   initial begin
      bit saw;
      n_chk            = 0;
      n_fail           = 0;
      reset            = 1'b0;
      pls_valid        = 1'b0;
      pls_data_request = 5'b00000;
      err_clr          = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_txd", 32'(txd), 32'd0);
      chk("rst_tx_en", 32'(tx_en), 32'd0);
      chk("rst_tx_er", 32'(tx_er), 32'd0);
      chk("rst_gtx_clk", 32'(gtx_clk), 32'd0);
      chk("rst_pls_ready", 32'(pls_ready), 32'd0);
      chk("rst_err", 32'(err_status), 32'd0);
      reset = 1'b1;
      idle(3);

      // A5 frame
      send(1); send(0); send(1); send(0); send(0); send(1); send(0); send(1);
      send(K_END);
      wait_out("t1_a5", DATA_W'(8'hA5), 1'b1, 1'b0, 60);
      idle(CLK_DIV);
      chk("t1_idle_txd", 32'(txd), 32'd0);
      chk("t1_idle_en", 32'(tx_en), 32'd0);
      chk("t1_idle_er", 32'(tx_er), 32'd0);
      chk("t1_err", 32'(err_status), 32'd0);

      // word, EXTEND, EXTEND_ERROR
      send_word(DATA_W'(8'h3C));
      send(K_EXT);
      send(K_EXT_ERR);
      send(K_END);
      wait_out("t2_ext", EXT_D, 1'b0, 1'b1, 60);
      idle(CLK_DIV);
      chk("t2_exterr_txd", 32'(txd), 32'(EXT_ERR_D));
      chk("t2_exterr_en", 32'(tx_en), 32'd0);
      chk("t2_exterr_er", 32'(tx_er), 32'd1);
      idle(10);

      // underrun then clear
      send_word(DATA_W'(8'h5A));
      wait_out("t4_underrun", '0, 1'b1, 1'b1, 60);
      chk("t4_err2", 32'(err_status[2]), 32'd1);
      send(K_END);
      idle(10);
      step(1'b0, 0, 1'b1);
      chk("t4_clr", 32'(err_status), 32'd0);

      // illegal symbol, set-over-clear, misaligned EXTEND
      send(K_ILL + 1);
      chk("t5_illegal", 32'(err_status[0]), 32'd1);
      step(1'b0, 0, 1'b1);
      chk("t5_clr", 32'(err_status), 32'd0);
      step(1'b1, K_ILL + 1, 1'b1);
      chk("t5_set_wins", 32'(err_status[0]), 32'd1);
      step(1'b0, 0, 1'b1);
      send(1); send(1); send(0);
      send(K_EXT);
      chk("t5_misalign", 32'(err_status[1]), 32'd1);
      wait_out("t5_ext_driven", EXT_D, 1'b0, 1'b1, 20);

      // back-pressure: symbols arrive faster than words drain
      saw = 1'b0;
      for (int i = 0; i < 4 * DEPTH; i++) begin
         step(1'b1, (i % 2 == 0) ? K_EXT : K_EXT_ERR, 1'b0);
         if (!pls_ready) saw = 1'b1;
      end
      chk("t3_ready_drop", 32'(saw), 32'd1);
      idle(40);

      // randomized phases: sparse, dense, starving
      for (int p = 0; p < 3; p++) begin
         int pct = (p == 0) ? 30 : (p == 1) ? 95 : 5;
         for (int i = 0; i < 800; i++) begin
            step(($urandom_range(99) < pct), rand_kind(), ($urandom_range(99) < 2));
         end
      end

      // asynchronous reset in the middle of a frame
      send_word(DATA_W'(8'h77));
      saw = 1'b0;
      for (int i = 0; i < 200 && !saw; i++) begin
         step(1'b0, 0, 1'b0);
         if (tx_en) saw = 1'b1;
      end
      chk("t6_in_frame", 32'(saw), 32'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_txd", 32'(txd), 32'd0);
      chk("t6_rst_en", 32'(tx_en), 32'd0);
      chk("t6_rst_er", 32'(tx_er), 32'd0);
      chk("t6_rst_gtx", 32'(gtx_clk), 32'd0);
      chk("t6_rst_ready", 32'(pls_ready), 32'd0);
      pls_valid = 1'b0;
      err_clr   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_reset();
      send(1); send(0); send(1); send(0); send(0); send(1); send(0); send(1);
      send(K_END);
      wait_out("t6_clean_a5", DATA_W'(8'hA5), 1'b1, 1'b0, 60);
      chk("t6_err_clean", 32'(err_status), 32'd0);
      idle(2 * CLK_DIV);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_tx_packer.md
Name: rs_tx_packer

Overview:
Parametrised transmit reconciliation-sublayer packer. Accepts one PLS_DATA.request symbol per accepted cycle (ZERO/ONE/EXTEND/EXTEND_ERROR/DATA_COMPLETE, one-hot) and packs data bits LSB-first into DATA_W-bit words. Words are buffered in a small FIFO and driven onto a GMII/MII-style txd/tx_en/tx_er interface, one word per gtx_clk period. Adds a valid/ready handshake, underrun error propagation and sticky error status.

Parameters:
DATA_W, 8, txd width; 8 = GMII, 4 = MII; only 4 and 8 are legal.
CLK_DIV, 2, gtx_clk period in clk cycles; even, ≥2.
DEPTH, 4, FIFO depth in entries; power of 2, ≥2.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
pls_data_request  in  5  one-hot symbol: 00001 ZERO, 00010 ONE, 00100 EXTEND_ERROR, 01000 EXTEND, 10000 DATA_COMPLETE.
pls_valid  in  1  symbol valid.
pls_ready  out  1  symbol accepted when pls_valid && pls_ready.
err_clr  in  1  single-cycle pulse; clears err_status.
gtx_clk  out  1  transmit clock, clk/CLK_DIV.
txd  out  DATA_W  transmit data.
tx_en  out  1  transmit enable.
tx_er  out  1  transmit error.
err_status  out  3  sticky flags: [0] illegal symbol, [1] misaligned, [2] underrun.

Behaviour:
- Reset (asserted low, asynchronous): all outputs 0; divider count 0; packer empty; FIFO empty; output FSM IDLE. pls_ready = 0 while reset is asserted.
- Divider: counter cnt runs 0..CLK_DIV-1.
  - gtx_clk = 1 while cnt < CLK_DIV/2.
  - tick = (cnt == CLK_DIV-1). txd/tx_en/tx_er update only on the clk edge ending a tick cycle, i.e. on the gtx_clk rising edge.
- pls_ready = (fifo_count < DEPTH), from registered state only.
- FIFO entry = {tag[1:0], data[DATA_W-1:0]}. Tags: DATA, EXT, EXT_ERR, END.
- Accepted symbol handling:
  - ZERO/ONE: bit shifted into packer position bit_cnt (LSB first). When bit_cnt reaches DATA_W, push DATA entry in the same cycle and set bit_cnt to 0.
  - EXTEND / EXTEND_ERROR: push EXT / EXT_ERR. If bit_cnt ≠ 0, discard the partial word, set err_status[1] and clear bit_cnt.
  - DATA_COMPLETE: push END. A partial word is handled as for EXTEND.
  - Non-one-hot value (including 0): dropped, no push, set err_status[0].
- At most one push per clk. A simultaneous push and pop leaves fifo_count unchanged.
- Output FSM, evaluated each tick:
  - IDLE, FIFO empty: txd=0, en=0, er=0.
  - Pop DATA: txd=data, en=1, er=0; go to FRAME.
  - Pop EXT: txd=0x0F, en=0, er=1. Pop EXT_ERR: txd=0x1F, en=0, er=1. (Truncated to DATA_W.) State unchanged.
  - Pop END: idle outputs; go to IDLE.
  - FRAME, FIFO empty: underrun; txd=0, en=1, er=1; set err_status[2]; stay in FRAME.
- Latency: a completed word appears at the first tick after the push cycle, behind any older entries.
- err_status: sticky. If a set and err_clr occur in the same cycle, set wins.

Optional Feature:
RS_TX_PREAMBLE_EN
- Defined: an IDLE→FRAME transition first inserts the preamble, then the DATA word, with en=1, er=0 throughout.
  - DATA_W=8: 7×0x55, then 0xD5.
  - DATA_W=4: 15×0x5, then 0xD.
  - The popped DATA word is held and not lost.
- Undefined: no preamble; the first DATA word is driven directly.

Decomposition:
- rs_tx_pkg holds:
  - symbol one-hot constants;
  - tag encodings;
  - EXT/EXT_ERR codes 0x0F/0x1F;
  - preamble/SFD constants;
  - output FSM state enum.
- Sub-module rs_tx_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/count, asynchronous active-low reset.

Test Plan:
1. DATA_W=8, CLK_DIV=2: bits 1,0,1,0,0,1,0,1 then DATA_COMPLETE → one tick with txd=0xA5, en=1, er=0; next tick txd=0x00, en=0, er=0; err_status=0.
2. One data word, then EXTEND, then EXTEND_ERROR at bit_cnt=0 → ticks show 0x0F (en=0, er=1), then 0x1F (en=0, er=1).
3. CLK_DIV=16, DEPTH=2, continuous valid with 40 bits → pls_ready drops with 2 entries queued; all 5 words appear in order with no loss.
4. CLK_DIV=2: one word, then pls_valid=0 for 40 cycles → tick shows txd=0x00, en=1, er=1; err_status[2]=1; err_clr pulse → 000.
5. Symbol 5'b00011 → dropped, err_status[0]=1. EXTEND after 3 bits → err_status[1]=1, and EXT is still driven.
6. Reset asserted mid-frame between clk edges → txd, tx_en, tx_er, gtx_clk go to 0 immediately; after release the next frame is clean.
   With RS_TX_PREAMBLE_EN: 0x55×7, 0xD5, then 0xA5.
